ram_bist_sequencer: RTL and testbench

Parametrised block-RAM self-test sequencer for the on-board RAM/PLL bring-up designs. It fills an internally inferred single-clock RAM with a selectable data pattern, reads every word back, and compares it against the regenerated pattern. It reports pass/fail, an error count and the first failing address, and can loop continuously with a per-iteration pattern shift. It replaces the free-running ROM→shift→FIFO→RAM LED chain with a self-checking, mode-selectable test.

---
 rtl/ram_bist_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ram_bist_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_sequencer.sv
// Block-RAM self-test sequencer: fills an internal RAM with a selectable
// pattern, reads it back through the registered read port, and compares each
// word against the regenerated pattern. Reports pass/fail, a saturating error
// count and the first failing address. It can loop with a per-iteration
// pattern offset.
module ram_bist_sequencer #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int ERR_CNT_WIDTH = 16,
   parameter int ITER_WIDTH    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_arstn,
   input  logic                     i_start,
   input  logic [1:0]               i_mode,
   input  logic                     i_loop,
   input  logic                     i_inject_err,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_pass,
   output logic                     o_fail,
   output logic [ERR_CNT_WIDTH-1:0] o_err_count,
   output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
   output logic [ITER_WIDTH-1:0]    o_iter
);

   localparam int DEPTH   = 1 << ADDR_WIDTH;
   localparam int SHIFT_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [1:0]               mode_q, mode_d;
   logic [ITER_WIDTH-1:0]    iter_q, iter_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic [ADDR_WIDTH-1:0]    first_addr_q, first_addr_d;
   logic                     first_flag_q, first_flag_d;
   logic                     pass_q, pass_d;
   logic                     fail_q, fail_d;
   logic                     cmp_valid_q, cmp_valid_d;
   logic [DATA_WIDTH-1:0]    exp_q, exp_d;
   logic [ADDR_WIDTH-1:0]    cmp_addr_q, cmp_addr_d;

   logic                     wr_en;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic [DATA_WIDTH-1:0]    pat;
   logic                     mismatch;
   logic [DATA_WIDTH-1:0]    ram_rdata;
   logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

   // Pattern generator P(a, k); sums are taken modulo 2^DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            mode,
      input logic [ADDR_WIDTH-1:0] a,
      input logic [ITER_WIDTH-1:0] k
   );
      logic [DATA_WIDTH-1:0] sum;
      logic [DATA_WIDTH-1:0] chk;
      sum = DATA_WIDTH'(a) + DATA_WIDTH'(k);
      chk = a[0] ? {(DATA_WIDTH/2){2'b10}} : {(DATA_WIDTH/2){2'b01}};
      case (mode)
         2'd0:    pattern = sum;
         2'd1:    pattern = DATA_WIDTH'(1) << sum[SHIFT_W-1:0];
         2'd2:    pattern = chk ^ {DATA_WIDTH{k[0]}};
         default: pattern = ~sum;
      endcase
   endfunction

   // Inferred single-port RAM with registered read; contents are not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[addr_q] <= wr_data;
      end
      ram_rdata <= mem[addr_q];
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         mode_q       <= '0;
         iter_q       <= '0;
         err_q        <= '0;
         first_addr_q <= '0;
         first_flag_q <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         cmp_valid_q  <= 1'b0;
         exp_q        <= '0;
         cmp_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         mode_q       <= mode_d;
         iter_q       <= iter_d;
         err_q        <= err_d;
         first_addr_q <= first_addr_d;
         first_flag_q <= first_flag_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         cmp_valid_q  <= cmp_valid_d;
         exp_q        <= exp_d;
         cmp_addr_q   <= cmp_addr_d;
      end
   end

   // Next-state, compare and RAM-control logic.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      mode_d       = mode_q;
      iter_d       = iter_q;
      err_d        = err_q;
      first_addr_d = first_addr_q;
      first_flag_d = first_flag_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      wr_en        = 1'b0;

      pat     = pattern(mode_q, addr_q, iter_q);
      wr_data = pat ^ DATA_WIDTH'(i_inject_err);

      // Expected word and address travel one cycle alongside the RAM read.
      cmp_valid_d = (state_q == S_READ);
      exp_d       = pat;
      cmp_addr_d  = addr_q;

      mismatch = cmp_valid_q && (ram_rdata != exp_q);
      if (mismatch) begin
         if (err_q != {ERR_CNT_WIDTH{1'b1}}) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
         end
         if (!first_flag_q) begin
            first_flag_d = 1'b1;
            first_addr_d = cmp_addr_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               mode_d       = i_mode;
               iter_d       = '0;
               err_d        = '0;
               first_addr_d = '0;
               first_flag_d = 1'b0;
               addr_d       = '0;
               state_d      = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_en  = 1'b1;
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            pass_d = (err_q == '0);
            fail_d = (err_q != '0);
            iter_d = iter_q + ITER_WIDTH'(1);
            if (i_loop) begin
               err_d        = '0;
               first_addr_d = '0;
               first_flag_d = 1'b0;
               state_d      = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_busy           = (state_q != S_IDLE);
   assign o_done           = (state_q == S_DONE);
   assign o_pass           = pass_q;
   assign o_fail           = fail_q;
   assign o_err_count      = err_q;
   assign o_first_err_addr = first_addr_q;
   assign o_iter           = iter_q;

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Directed bench for ram_bist_sequencer (8-bit data, 16 words, 3-bit error
// counter): table-driven single runs plus hand-written looping, disturbance
// and mid-run reset sequences.
module tb_ram_bist_sequencer;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int EW = 3;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          arstn = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          loop_i = 1'b0;
   logic          inj = 1'b0;
   logic          busy, done, pass, fail;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_addr;
   logic [IW-1:0] iter;

   int n_cmp = 0;
   int n_bad = 0;

   ram_bist_sequencer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_WIDTH(EW), .ITER_WIDTH(IW)
   ) dut (
      .i_clk(clk), .i_arstn(arstn), .i_start(start), .i_mode(mode),
      .i_loop(loop_i), .i_inject_err(inj),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail(fail),
      .o_err_count(err_count), .o_first_err_addr(first_addr), .o_iter(iter)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      int         inj_addr;
      bit         inj_all;
      int         exp_pass;
      int         exp_fail;
      int         exp_err;
      int         exp_first;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference for the write pattern (8-bit words).
   function automatic int model_pat(input int m, input int a, input int k);
      int s;
      int r;
      s = a + k;
      r = 0;
      case (m)
         0: r = s % 256;
         1: r = 1 << (s % 8);
         2: for (int i = 0; i < 8; i++) if (((i + a + k) % 2) == 0) r = r | (1 << i);
         default: r = 255 - (s % 256);
      endcase
      return r;
   endfunction

   // One 34-cycle iteration starting with the edge that enters WRITE.
   task automatic do_iter(input logic [1:0] m, input int k, input int inj_addr,
                          input bit inj_all, input bit loop_val, input bit disturb,
                          input int exp_prev);
      int expw;
      for (int c = 1; c <= 34; c++) begin
         tick();
         if (c == 1) begin
            start  = 1'b0;
            loop_i = loop_val;
         end
         inj = (c <= 16) && (inj_all || ((c - 1) == inj_addr));
         if (disturb) begin
            if (c == 5) mode = ~m;
            start  = (c >= 20 && c <= 30);
            loop_i = (c >= 2 && c <= 33) ? 1'b1 : loop_val;
         end
         #1;
         if (c == 1) begin
            check("busy_rise", busy, 1);
            check("iter_at_start", iter, k);
            if (exp_prev >= 0) begin
               check("prev_pass", pass, exp_prev);
               check("prev_fail", fail, 1 - exp_prev);
            end
         end
         check("done_timing", done, (c == 34) ? 1 : 0);
         check("wr_en", dut.wr_en, (c <= 16) ? 1 : 0);
         if (c <= 16) begin
            expw = model_pat(m, c - 1, k) ^ (inj ? 1 : 0);
            check("wr_data", dut.wr_data, expw);
         end
         if (c == 34) check("busy_done", busy, 1);
      end
      inj = 1'b0;
   endtask

   task automatic check_end(input string tag, input int ep, input int ef,
                            input int ee, input int efa, input int ei);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, ep);
      check({tag, "_fail"}, fail, ef);
      check({tag, "_err"}, err_count, ee);
      check({tag, "_first"}, first_addr, efa);
      check({tag, "_iter"}, iter, ei);
   endtask

   initial begin
      //            mode  inj  all  pass fail err first
      vecs[0] = '{2'd0, -1,  1'b0, 1,   0,   0,  0};
      vecs[1] = '{2'd1, -1,  1'b0, 1,   0,   0,  0};
      vecs[2] = '{2'd2,  5,  1'b0, 0,   1,   1,  5};
      vecs[3] = '{2'd3,  0,  1'b0, 0,   1,   1,  0};
      vecs[4] = '{2'd2, -1,  1'b1, 0,   1,   7,  0};
      vecs[5] = '{2'd0, 15,  1'b0, 0,   1,   1, 15};
      vecs[6] = '{2'd1, -1,  1'b1, 0,   1,   7,  0};

      // Reset state.
      repeat (3) tick();
      check_end("reset", 0, 0, 0, 0, 0);
      arstn = 1'b1;
      tick();

      // Single runs from the table.
      for (int v = 0; v < 7; v++) begin
         mode  = vecs[v].mode;
         start = 1'b1;
         #1;
         check("idle_busy", busy, 0);
         do_iter(vecs[v].mode, 0, vecs[v].inj_addr, vecs[v].inj_all, 1'b0, 1'b0, -1);
         tick();
         check_end("vec", vecs[v].exp_pass, vecs[v].exp_fail, vecs[v].exp_err,
                   vecs[v].exp_first, 1);
         $display("vector %0d mode=%0d inj=%0d all=%0d -> pass=%0d fail=%0d err=%0d first=%0d",
                  v, vecs[v].mode, vecs[v].inj_addr, vecs[v].inj_all, pass, fail,
                  err_count, first_addr);
         tick();
      end

      // Looping, walking one, three back-to-back iterations.
      mode  = 2'd1;
      start = 1'b1;
      do_iter(2'd1, 0, -1, 1'b0, 1'b1, 1'b0, -1);
      do_iter(2'd1, 1, -1, 1'b0, 1'b1, 1'b0, 1);
      do_iter(2'd1, 2, -1, 1'b0, 1'b0, 1'b0, 1);
      tick();
      check_end("loop3", 1, 0, 0, 0, 3);
      $display("loop mode=1 x3 -> iter=%0d pass=%0d", iter, pass);
      tick();

      // Looping with an error in the first iteration: cleared for the second.
      mode  = 2'd3;
      start = 1'b1;
      do_iter(2'd3, 0, 7, 1'b0, 1'b1, 1'b0, -1);
      check("loop_err_before_clear", err_count, 1);
      check("loop_first_before_clear", first_addr, 7);
      do_iter(2'd3, 1, -1, 1'b0, 1'b0, 1'b0, 0);
      tick();
      check_end("loopclr", 1, 0, 0, 0, 2);
      $display("loop mode=3 err-then-clean -> iter=%0d pass=%0d err=%0d", iter, pass, err_count);
      tick();

      // Start during READ, mode change mid-run, loop outside DONE: all ignored.
      mode  = 2'd0;
      start = 1'b1;
      do_iter(2'd0, 0, -1, 1'b0, 1'b0, 1'b1, -1);
      mode = 2'd0;
      tick();
      check_end("disturb", 1, 0, 0, 0, 1);
      repeat (3) tick();
      check("disturb_stays_idle", busy, 0);
      $display("disturbance run -> pass=%0d iter=%0d busy=%0d", pass, iter, busy);

      // Mid-run reset at cycle 20 with one error already counted.
      mode  = 2'd2;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         inj = (c == 2);
      end
      inj = 1'b0;
      #1;
      check("pre_reset_err", err_count, 1);
      check("pre_reset_first", first_addr, 1);
      check("pre_reset_pass", pass, 1);
      check("pre_reset_busy", busy, 1);
      arstn = 1'b0;
      #1;
      check_end("abort", 0, 0, 0, 0, 0);
      tick();
      tick();
      arstn = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         check("post_reset_idle", busy, 0);
         check("post_reset_nodone", done, 0);
      end
      $display("mid-run reset -> busy=%0d pass=%0d err=%0d", busy, pass, err_count);

      // Normal run after the abort.
      mode  = 2'd0;
      start = 1'b1;
      do_iter(2'd0, 0, -1, 1'b0, 1'b0, 1'b0, -1);
      tick();
      check_end("after_abort", 1, 0, 0, 0, 1);
      $display("run after reset -> pass=%0d iter=%0d", pass, iter);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
